game_flow_ctl: RTL and testbench
================================

GAME_FLOW_CTL -- requirements
Module: game_flow_ctl

Interface
REQ-001 Parameter ROUND_FRAMES, default 1800, SHALL set play-round length in frames (30 s at 60 Hz).
REQ-002 Parameter DUCK_FRAMES, default 120, SHALL set the number of frames a duck stays before forced respawn.
REQ-003 Parameter SCORE_FRAMES, default 300, SHALL set the minimum number of frames the score screen is held.
REQ-004 pclk  in  1  pixel clock; all logic is on the rising edge of this clock.
REQ-005 rst  in  1  reset, synchronous and active-low; 0 = reset.
REQ-006 vblnk  in  1  vertical blank from timing; each 0->1 edge is one frame tick.
REQ-007 play_clicked  in  1  one-cycle pulse when the play button is clicked.
REQ-008 duck_hit  in  1  one-cycle pulse when the duck is clicked.
REQ-009 mouse_left  in  1  synchronised left mouse button level.
REQ-010 rx_valid / rx_data  in  1 / 8  UART receive byte strobe and data.
REQ-011 tx_ready  in  1  UART transmitter can accept a byte.
REQ-012 tx_valid / tx_data  out  1 / 8  UART transmit request and byte.
REQ-013 state  out  2  0=IDLE, 1=WAIT, 2=PLAY, 3=SCORE.
REQ-014 duck_respawn  out  1  one-cycle pulse requesting a new random duck position.
REQ-015 score / op_score  out  7 / 7  own hits and opponent hits, binary 0..99.
REQ-016 op_valid  out  1  opponent score received for the current round.
REQ-017 frames_left  out  11  remaining frames of the round.

Function
REQ-018 All outputs SHALL be registered; a state change SHALL be visible on state one cycle after the triggering input.
REQ-019 Frame-tick rule: the block SHALL detect a vblnk rising edge with a one-register delay, and at most one tick SHALL occur per frame.
REQ-020 IDLE: on play_clicked the block SHALL queue tx byte 8'h53 ("S") and go to WAIT.
REQ-021 In IDLE or WAIT, rx_valid with rx_data=8'h53 SHALL set peer_ready; other bytes SHALL be ignored.
REQ-022 WAIT -> PLAY SHALL occur when peer_ready=1 and no tx byte is pending.
REQ-023 If peer_ready is already set when entering WAIT, the block SHALL go to PLAY as soon as the "S" byte is accepted.
REQ-024 Entry to PLAY SHALL clear score, op_score and op_valid, load frames_left=ROUND_FRAMES, load the duck timer to DUCK_FRAMES, and pulse duck_respawn.
REQ-025 PLAY, on each tick: frames_left SHALL decrement and the duck timer SHALL decrement.
REQ-026 When the duck timer decrements to 0, the block SHALL pulse duck_respawn and reload the timer.
REQ-027 PLAY, on duck_hit: score SHALL increment, saturating at 99; the block SHALL pulse duck_respawn and reload the duck timer.
REQ-028 A duck_hit and a duck-timer expiry in the same cycle SHALL produce exactly one duck_respawn pulse and one score increment.
REQ-029 When frames_left reaches 0, the block SHALL go to SCORE and queue tx byte {1'b1, score}; a duck_hit in that same cycle SHALL be counted before the byte is built.
REQ-030 duck_hit outside PLAY SHALL be ignored.
REQ-031 SCORE: rx_valid with rx_data[7]=1 SHALL load op_score=rx_data[6:0], saturated at 99, and set op_valid.
REQ-032 SCORE: the hold counter SHALL count ticks up to SCORE_FRAMES.
REQ-033 SCORE -> IDLE SHALL occur on a mouse_left 0->1 edge only when op_valid=1 and the hold count has been reached; peer_ready SHALL be cleared on this transition.
REQ-034 TX handshake: tx_valid SHALL stay high with tx_data stable until the cycle tx_ready=1, then drop the next cycle.
REQ-035 TX queue: the single tx slot SHALL never be overwritten while pending.
REQ-036 rx_valid in PLAY SHALL be ignored.

Reset
REQ-037 While rst=0 at a clock edge, the block SHALL set state=IDLE, tx_valid=0, tx_data=0, duck_respawn=0, score=0, op_score=0, op_valid=0, frames_left=0, and clear peer_ready and all counters.
REQ-038 Reset mid-round SHALL abort any pending tx byte without completing the handshake.

Structure
REQ-039 A shared game package SHALL hold the state encoding, the byte 8'h53, the score-byte flag bit, and SCORE_MAX=99.
REQ-040 One sub-module, frame_tick, SHALL perform vblnk edge detection; the FSM, timers and tx slot SHALL stay in game_flow_ctl.

Verification
REQ-041 Handshake: with tx_ready=1, play_clicked, then rx 8'h53 -> tx_data=8'h53 for one cycle, state WAIT, then PLAY; frames_left=1800; one duck_respawn pulse.
REQ-042 Early peer and stall: rx 8'h53 in IDLE, tx_ready held 0 for 50 cycles, then play_clicked -> state stays WAIT with tx_valid high; the cycle after tx_ready=1, state=PLAY.
REQ-043 Timeout and collision: with no hits for 120 ticks -> exactly one duck_respawn pulse; duck_hit on the expiry cycle -> one pulse and score+1.
REQ-044 Saturation and end of round: 105 hits -> score=99; the round ends after 1800 ticks -> state=SCORE and tx_data=8'hE3.
REQ-045 SCORE exit: mouse click before op byte or before 300 ticks -> stays SCORE; rx 8'h8C -> op_score=12, op_valid=1; a later click -> IDLE.
REQ-046 Reset in PLAY with tx pending -> all outputs at reset values the next cycle and tx_valid=0.

Source files
------------

// File: rtl/game_flow_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctl_pkg
// Purpose  : Shared definitions for the duck-game flow controller: state
//            encoding, link protocol bytes and score limit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package game_flow_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_SCORE = 2'd3
  } state_e;

  // "S": both sides send this to announce they are ready to start a round.
  localparam logic [7:0] START_BYTE = 8'h53;
  // Bit 7 set marks a byte as a score report; bits 6:0 carry the score.
  localparam logic [7:0] SCORE_FLAG = 8'h80;
  localparam logic [6:0] SCORE_MAX  = 7'd99;

  // Clamp an 8-bit value into the 0..99 score range.
  function automatic logic [6:0] sat_score(input logic [7:0] value);
    return (value > {1'b0, SCORE_MAX}) ? SCORE_MAX : value[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_ctl_frame_tick.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick
// Purpose  : Turns the vertical-blank level into a single-cycle frame tick
//            on each 0->1 edge (one tick per frame).
// Ports    : pclk_i  - pixel clock
//            rst_i   - synchronous reset, active low
//            vblnk_i - vertical blank level from the video timing
//            tick_o  - one-cycle pulse on the vblnk rising edge
// Revision : 1.0 - initial release
// ============================================================================
module frame_tick
  import game_flow_ctl_pkg::*;
(
  input  logic pclk_i,
  input  logic rst_i,
  input  logic vblnk_i,
  output logic tick_o
);

  logic vblnk_q;

  // Reset to 1 so a vblnk already high when reset releases is not taken
  // as a fresh frame edge.
  always_ff @(posedge pclk_i) begin
    if (!rst_i) begin
      vblnk_q <= 1'b1;
    end else begin
      vblnk_q <= vblnk_i;
    end
  end

  assign tick_o = vblnk_i & ~vblnk_q;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctl.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctl
// Purpose  : Round sequencer for a two-player duck game linked over UART.
//            IDLE -> WAIT (exchange "S") -> PLAY (timed round, duck timer,
//            hit counting) -> SCORE (swap scores, hold, click to leave).
// Ports    : pclk, rst (sync, active low), vblnk (frame timing)
//            play_clicked, duck_hit, mouse_left  - UI events
//            rx_valid/rx_data                    - UART receive
//            tx_ready, tx_valid/tx_data          - UART transmit handshake
//            state, duck_respawn, score, op_score, op_valid, frames_left
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_ctl
  import game_flow_ctl_pkg::*;
#(
  parameter int ROUND_FRAMES = 1800,
  parameter int DUCK_FRAMES  = 120,
  parameter int SCORE_FRAMES = 300
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        play_clicked,
  input  logic        duck_hit,
  input  logic        mouse_left,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [1:0]  state,
  output logic        duck_respawn,
  output logic [6:0]  score,
  output logic [6:0]  op_score,
  output logic        op_valid,
  output logic [10:0] frames_left
);

  localparam int DUCK_W = $clog2(DUCK_FRAMES + 1);
  localparam int HOLD_W = $clog2(SCORE_FRAMES + 1);

  localparam logic [10:0]       ROUND_LOAD = 11'(ROUND_FRAMES);
  localparam logic [DUCK_W-1:0] DUCK_LOAD  = DUCK_W'(DUCK_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(SCORE_FRAMES);

  state_e            state_q, state_d;
  logic              peer_ready_q, peer_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              duck_respawn_q, duck_respawn_d;
  logic [6:0]        score_q, score_d;
  logic [6:0]        op_score_q, op_score_d;
  logic              op_valid_q, op_valid_d;
  logic [10:0]       frames_left_q, frames_left_d;
  logic [DUCK_W-1:0] duck_cnt_q, duck_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              mouse_q;

  logic       w_tick;
  logic       w_tx_accept;
  logic       w_tx_free;
  logic       w_rx_start;
  logic       w_mouse_rise;
  logic       w_duck_expire;
  logic       w_hold_done;
  logic [6:0] w_score_inc;

  frame_tick u_frame_tick (
    .pclk_i  (pclk),
    .rst_i   (rst),
    .vblnk_i (vblnk),
    .tick_o  (w_tick)
  );

  assign w_tx_accept   = tx_valid_q & tx_ready;
  // The slot may take a new byte when empty or when its byte leaves this edge.
  assign w_tx_free     = ~tx_valid_q | tx_ready;
  assign w_rx_start    = rx_valid & (rx_data == START_BYTE);
  assign w_mouse_rise  = mouse_left & ~mouse_q;
  assign w_duck_expire = w_tick & (duck_cnt_q == DUCK_W'(1));
  assign w_hold_done   = (hold_cnt_q == HOLD_LAST);
  assign w_score_inc   = sat_score({1'b0, score_q} + 8'd1);

  always_comb begin
    state_d        = state_q;
    peer_ready_d   = peer_ready_q;
    tx_valid_d     = tx_valid_q;
    tx_data_d      = tx_data_q;
    duck_respawn_d = 1'b0;
    score_d        = score_q;
    op_score_d     = op_score_q;
    op_valid_d     = op_valid_q;
    frames_left_d  = frames_left_q;
    duck_cnt_d     = duck_cnt_q;
    hold_cnt_d     = hold_cnt_q;

    if (w_tx_accept) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_rx_start) begin
          peer_ready_d = 1'b1;
        end
        if (play_clicked && w_tx_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = START_BYTE;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (w_rx_start) begin
          peer_ready_d = 1'b1;
        end
        // Start only once our "S" is gone (already, or leaving this edge).
        if (peer_ready_q && (!tx_valid_q || tx_ready)) begin
          state_d        = ST_PLAY;
          score_d        = 7'd0;
          op_score_d     = 7'd0;
          op_valid_d     = 1'b0;
          frames_left_d  = ROUND_LOAD;
          duck_cnt_d     = DUCK_LOAD;
          duck_respawn_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (w_tick) begin
          frames_left_d = frames_left_q - 11'd1;
          duck_cnt_d    = duck_cnt_q - DUCK_W'(1);
        end
        // Hit and timeout on the same cycle merge into one respawn.
        if (duck_hit || w_duck_expire) begin
          duck_respawn_d = 1'b1;
          duck_cnt_d     = DUCK_LOAD;
        end
        if (duck_hit) begin
          score_d = w_score_inc;
        end
        if (w_tick && (frames_left_q == 11'd1)) begin
          state_d    = ST_SCORE;
          hold_cnt_d = '0;
          // score_d already includes a hit landing on this last frame.
          // The slot is always empty here: PLAY is entered only after "S" left.
          if (w_tx_free) begin
            tx_valid_d = 1'b1;
            tx_data_d  = SCORE_FLAG | {1'b0, score_d};
          end
        end
      end

      ST_SCORE: begin
        if (rx_valid && ((rx_data & SCORE_FLAG) != 8'd0)) begin
          op_score_d = sat_score({1'b0, rx_data[6:0]});
          op_valid_d = 1'b1;
        end
        if (w_tick && !w_hold_done) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if (w_mouse_rise && op_valid_q && w_hold_done) begin
          state_d      = ST_IDLE;
          peer_ready_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      peer_ready_q   <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'd0;
      duck_respawn_q <= 1'b0;
      score_q        <= 7'd0;
      op_score_q     <= 7'd0;
      op_valid_q     <= 1'b0;
      frames_left_q  <= 11'd0;
      duck_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      mouse_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      peer_ready_q   <= peer_ready_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      duck_respawn_q <= duck_respawn_d;
      score_q        <= score_d;
      op_score_q     <= op_score_d;
      op_valid_q     <= op_valid_d;
      frames_left_q  <= frames_left_d;
      duck_cnt_q     <= duck_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      mouse_q        <= mouse_left;
    end
  end

  assign state        = state_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign duck_respawn = duck_respawn_q;
  assign score        = score_q;
  assign op_score     = op_score_q;
  assign op_valid     = op_valid_q;
  assign frames_left  = frames_left_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_ctl
// Purpose  : Directed self-checking bench for game_flow_ctl with default
//            parameters (1800-frame round, 120-frame duck, 300-frame hold).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        play_clicked;
  logic        duck_hit;
  logic        mouse_left;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [1:0]  state;
  logic        duck_respawn;
  logic [6:0]  score;
  logic [6:0]  op_score;
  logic        op_valid;
  logic [10:0] frames_left;

  int total = 0;
  int bad   = 0;
  int pulses;

  game_flow_ctl dut (
    .pclk         (pclk),
    .rst          (rst),
    .vblnk        (vblnk),
    .play_clicked (play_clicked),
    .duck_hit     (duck_hit),
    .mouse_left   (mouse_left),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .state        (state),
    .duck_respawn (duck_respawn),
    .score        (score),
    .op_score     (op_score),
    .op_valid     (op_valid),
    .frames_left  (frames_left)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n frames of vblnk high/low, counting respawn pulses seen on the way.
  task automatic run_ticks(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      vblnk = 1'b1;
      cyc();
      if (duck_respawn) cnt++;
      vblnk = 1'b0;
      cyc();
      if (duck_respawn) cnt++;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc();
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic click();
    mouse_left = 1'b1;
    cyc();
    mouse_left = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0; vblnk = 1'b0; play_clicked = 1'b0; duck_hit = 1'b0;
    mouse_left = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
    repeat (3) cyc();
    check("rst_state", state, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_respawn", duck_respawn, 0);
    check("rst_score", score, 0);
    check("rst_op_score", op_score, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_frames", frames_left, 0);
    rst = 1'b1;
    cyc();

    // ---- Round 1: plain handshake ----
    tx_ready = 1'b1;
    play_clicked = 1'b1;
    cyc();
    play_clicked = 1'b0;
    check("hs_state_wait", state, 1);
    check("hs_tx_valid", tx_valid, 1);
    check("hs_tx_data", tx_data, 8'h53);
    cyc();
    check("hs_tx_drop", tx_valid, 0);
    check("hs_still_wait", state, 1);
    rx_byte(8'h53);
    check("hs_wait_after_rx", state, 1);
    cyc();
    check("hs_state_play", state, 2);
    check("hs_frames", frames_left, 1800);
    check("hs_respawn", duck_respawn, 1);
    check("hs_score0", score, 0);
    cyc();
    check("hs_respawn_once", duck_respawn, 0);

    // Duck timeout and collision
    run_ticks(120, pulses);
    check("timeout_pulses", pulses, 1);
    check("timeout_frames", frames_left, 1680);
    run_ticks(119, pulses);
    check("pre_collide_pulses", pulses, 0);
    vblnk = 1'b1; duck_hit = 1'b1;
    cyc();
    vblnk = 1'b0; duck_hit = 1'b0;
    check("collide_respawn", duck_respawn, 1);
    check("collide_score", score, 1);
    cyc();
    check("collide_single", duck_respawn, 0);
    check("collide_frames", frames_left, 1560);
    run_ticks(120, pulses);
    check("reload_pulses", pulses, 1);
    check("reload_frames", frames_left, 1440);

    // Score saturation: 105 hits in total
    for (int i = 0; i < 97; i++) begin
      duck_hit = 1'b1;
      cyc();
    end
    duck_hit = 1'b0;
    check("score_98", score, 98);
    for (int i = 0; i < 7; i++) begin
      duck_hit = 1'b1;
      cyc();
    end
    duck_hit = 1'b0;
    check("score_sat99", score, 99);

    // End of round
    run_ticks(1439, pulses);
    check("last_frame_state", state, 2);
    check("last_frame_frames", frames_left, 1);
    vblnk = 1'b1;
    cyc();
    vblnk = 1'b0;
    check("end_state", state, 3);
    check("end_tx_valid", tx_valid, 1);
    check("end_tx_data", tx_data, 8'hE3);
    check("end_frames", frames_left, 0);
    cyc();
    check("end_tx_drop", tx_valid, 0);

    // SCORE screen
    duck_hit = 1'b1;
    cyc();
    duck_hit = 1'b0;
    check("score_hit_ignored", score, 99);
    check("score_hit_no_respawn", duck_respawn, 0);
    click();
    check("click_no_op", state, 3);
    rx_byte(8'h05);
    check("rx_noflag_ignored", op_valid, 0);
    rx_byte(8'hFF);
    check("op_sat", op_score, 99);
    check("op_valid_set", op_valid, 1);
    rx_byte(8'h8C);
    check("op_12", op_score, 12);
    click();
    check("click_no_hold", state, 3);
    run_ticks(299, pulses);
    click();
    check("click_hold_299", state, 3);
    run_ticks(1, pulses);
    mouse_left = 1'b1;
    cyc();
    mouse_left = 1'b0;
    check("click_exit_idle", state, 0);
    cyc();

    // Peer-ready must have been cleared on leaving SCORE
    play_clicked = 1'b1;
    cyc();
    play_clicked = 1'b0;
    check("peer_cleared_wait", state, 1);
    repeat (3) cyc();
    check("peer_cleared_stay", state, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("rst_back_idle", state, 0);

    // ---- Round 2: early peer and tx stall ----
    rx_byte(8'h41);
    rx_byte(8'h53);
    tx_ready = 1'b0;
    play_clicked = 1'b1;
    cyc();
    play_clicked = 1'b0;
    check("stall_wait", state, 1);
    check("stall_tx_valid", tx_valid, 1);
    repeat (50) cyc();
    check("stall_still_wait", state, 1);
    check("stall_tx_hold", tx_valid, 1);
    check("stall_tx_data", tx_data, 8'h53);
    tx_ready = 1'b1;
    cyc();
    check("stall_play", state, 2);
    check("stall_tx_drop", tx_valid, 0);
    check("stall_respawn", duck_respawn, 1);
    check("entry_op_clear", op_score, 0);
    check("entry_opv_clear", op_valid, 0);
    check("entry_score_clear", score, 0);
    check("entry_frames", frames_left, 1800);
    tx_ready = 1'b0;
    run_ticks(1799, pulses);
    check("r2_last_frames", frames_left, 1);
    vblnk = 1'b1; duck_hit = 1'b1;
    cyc();
    vblnk = 1'b0; duck_hit = 1'b0;
    check("r2_end_state", state, 3);
    check("r2_end_score", score, 1);
    check("r2_end_tx_data", tx_data, 8'h81);
    repeat (5) cyc();
    check("r2_tx_pending", tx_valid, 1);
    check("r2_tx_stable", tx_data, 8'h81);

    // Reset with a byte pending
    rst = 1'b0;
    cyc();
    check("prst_state", state, 0);
    check("prst_tx_valid", tx_valid, 0);
    check("prst_tx_data", tx_data, 0);
    check("prst_respawn", duck_respawn, 0);
    check("prst_score", score, 0);
    check("prst_op_score", op_score, 0);
    check("prst_op_valid", op_valid, 0);
    check("prst_frames", frames_left, 0);
    rst = 1'b1;
    tx_ready = 1'b1;
    cyc();
    check("prst_tx_aborted", tx_valid, 0);

    // ---- Round 3: reset mid-PLAY ----
    rx_byte(8'h53);
    play_clicked = 1'b1;
    cyc();
    play_clicked = 1'b0;
    cyc();
    check("r3_play", state, 2);
    run_ticks(3, pulses);
    duck_hit = 1'b1;
    cyc();
    duck_hit = 1'b0;
    check("r3_score", score, 1);
    rst = 1'b0;
    cyc();
    check("r3_rst_state", state, 0);
    check("r3_rst_frames", frames_left, 0);
    check("r3_rst_score", score, 0);
    check("r3_rst_respawn", duck_respawn, 0);
    rst = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
